alu_mdu: RTL

Parametrised, registered successor to the core ALU. It adds logic, compare and shift ops and an iterative multiply/divide engine with HI/LO registers for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO.
It sits in the EX stage. The control unit issues an op with a one-cycle start pulse and stalls on busy until done.
Single-cycle ops complete in 1 cycle. Multiply/divide complete in WIDTH+2 cycles.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_mdu_iter.sv | 129 ++++++++++++
 rtl/alu_mdu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU/MDU: op codes, FSM encodings,
// and op-class helpers used by both the top and the iterative engine.
package alu_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NOR    = 4'd5;
    localparam logic [3:0] OP_SLT    = 4'd6;
    localparam logic [3:0] OP_SLTU   = 4'd7;
    localparam logic [3:0] OP_SLL    = 4'd8;
    localparam logic [3:0] OP_SRL    = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_MULT   = 4'd11;
    localparam logic [3:0] OP_MULTU  = 4'd12;
    localparam logic [3:0] OP_DIV    = 4'd13;
    localparam logic [3:0] OP_DIVU   = 4'd14;
    localparam logic [3:0] OP_MTHILO = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } alu_state_e;

    // Ops that go through the iterative multiply/divide engine.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // Signed variants of the multiply/divide ops.
    function automatic logic is_signed_md(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Multiply (as opposed to divide) variants.
    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply/divide engine. Works on operand magnitudes for WIDTH
// cycles (shift-add multiply or restoring divide, one bit per cycle), then
// spends one cycle applying the sign fix-up, during which valid is high and
// hi/lo carry the final values.
//
// Handshake: start is a single-cycle load pulse, only issued while the engine
// is idle; last is high during the final RUN cycle; valid is high for exactly
// the one fix-up cycle that follows, and hi/lo/dz are meaningful only then.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic             mul,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             valid,
    output logic             last,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    logic             running;
    logic             fixing;
    logic [CW-1:0]    cnt;
    logic             mul_q;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    logic             x_neg;
    logic             y_neg;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes and the per-cycle datapath for both algorithms.
    always_comb begin
        x_neg   = sgn & x[WIDTH-1];
        y_neg   = sgn & y[WIDTH-1];
        x_mag   = x_neg ? (~x + 1'b1) : x;
        y_mag   = y_neg ? (~y + 1'b1) : y;
        add_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        trial   = {p_hi, p_lo[WIDTH-1]} - {1'b0, m_q};
    end

    // Load operands on start, then step one bit per cycle until the counter
    // runs out; the cycle after the last step is the fix-up cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            fixing  <= 1'b0;
            cnt     <= '0;
            mul_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            x_q     <= '0;
            m_q     <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
        end else if (start) begin
            running <= 1'b1;
            fixing  <= 1'b0;
            cnt     <= CNT_TOP;
            mul_q   <= mul;
            neg_q   <= x_neg ^ y_neg;
            neg_r   <= x_neg;
            dz_q    <= !mul && (y == '0);
            x_q     <= x;
            m_q     <= mul ? x_mag : y_mag;
            p_hi    <= '0;
            p_lo    <= mul ? y_mag : x_mag;
        end else if (running) begin
            if (mul_q) begin
                {p_hi, p_lo} <= {add_sum, p_lo[WIDTH-1:1]};
            end else begin
                p_hi <= trial[WIDTH] ? {p_hi[WIDTH-2:0], p_lo[WIDTH-1]} : trial[WIDTH-1:0];
                p_lo <= {p_lo[WIDTH-2:0], ~trial[WIDTH]};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                running <= 1'b0;
                fixing  <= 1'b1;
            end
        end else begin
            fixing <= 1'b0;
        end
    end

    // Sign fix-up and divide-by-zero override, presented during the fix cycle.
    always_comb begin
        prod     = {p_hi, p_lo};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        q_fix    = neg_q ? (~p_lo + 1'b1) : p_lo;
        r_fix    = neg_r ? (~p_hi + 1'b1) : p_hi;
        if (mul_q) begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
            hi = x_q;
            lo = '1;
        end else begin
            hi = r_fix;
            lo = q_fix;
        end
        valid = fixing;
        last  = running && (cnt == '0);
        dz    = dz_q && !mul_q;
    end

endmodule

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU with an attached iterative multiply/divide unit
// and HI/LO registers. Single-cycle ops finish on the accepting edge; MDU ops
// hold busy through RUN and FIX and write hi/lo/result on FIX->IDLE.
//
// Handshake: an op is accepted on a rising edge where start=1 and the FSM is
// IDLE (busy=0); start while busy is dropped. done pulses for exactly one
// cycle after the edge that commits the op's results.
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [SH_W-1:0]  shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alu_state_e       state;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             mdu_start;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;
    logic             mdu_valid;
    logic             mdu_last;
    logic             mdu_dz;

    assign accept    = start && (state == ST_IDLE);
    assign mdu_start = accept && is_multicycle(op);
    assign busy      = (state != ST_IDLE);

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdu_start),
        .sgn   (is_signed_md(op)),
        .mul   (is_mul(op)),
        .x     (x),
        .y     (y),
        .hi    (mdu_hi),
        .lo    (mdu_lo),
        .valid (mdu_valid),
        .last  (mdu_last),
        .dz    (mdu_dz)
    );

    // Single-cycle result and signed-overflow flag for the current op.
    always_comb begin
        sum     = x + y;
        diff    = x - y;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:    alu_res = x & y;
            OP_OR:     alu_res = x | y;
            OP_XOR:    alu_res = x ^ y;
            OP_NOR:    alu_res = ~(x | y);
            OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU:   alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_SLL:    alu_res = y << shamt;
            OP_SRL:    alu_res = y >> shamt;
            OP_SRA:    alu_res = $signed(y) >>> shamt;
            OP_MTHILO: alu_res = y;
            default:   alu_res = '0;
        endcase
    end

    // Control FSM plus the result, flag and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_multicycle(op)) begin
                            state <= ST_RUN;
                        end else begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            done     <= 1'b1;
                            if (op == OP_MTHILO) begin
                                hi <= x;
                                lo <= y;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (mdu_last) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (mdu_valid) begin
                        hi       <= mdu_hi;
                        lo       <= mdu_lo;
                        result   <= mdu_lo;
                        zero     <= (mdu_lo == '0);
                        overflow <= 1'b0;
                        div_zero <= mdu_dz;
                        done     <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
